spi_arbiter: RTL
================

# spi_arbiter

Round-robin scheduler that shares one SPI master (CS/SCK timing controller plus shift datapath) between `req_num` local requesters. It latches a requester's transfer descriptor (mode, widths, write word, CPOL/CPHA) and drives the master's configuration and `en`. It waits for the master's completion pulse, then returns the read word and an acknowledge to the winning requester. A watchdog aborts hung transfers, and malformed descriptors are rejected without touching the bus.

## Interface
Parameters:
- `req_num`, 4: number of requesters, 2..8.
- `timeout_cycles`, 4096: maximum `clk` cycles in RUN before abort, ≥ 2.
- `gap_cycles`, 2: idle cycles with `spi_en` low between transfers, ≥ 1.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input `req_num`: per-requester request level; held until `ack` or `err`.
- `req_w_r_mode` input `2*req_num`: per-requester mode. 00 read, 01 write, 10 write-then-read, 11 illegal.
- `req_wr_width` input `6*req_num`: write bit count, legal 1..32.
- `req_rd_width` input `6*req_num`: read bit count, legal 1..32.
- `req_wr_data` input `32*req_num`: write word, MSB-aligned.
- `req_cpol` input `req_num`: per-requester clock polarity.
- `req_cpha` input `req_num`: per-requester clock phase.
- `gnt` output `req_num`: one-hot, high from LOAD through end of RUN.
- `ack` output `req_num`: one-cycle pulse on successful completion.
- `err` output `req_num`: one-cycle pulse on reject or timeout.
- `rd_data` output 32: read word, valid in the `ack` cycle and held until the next `ack`.
- `spi_en` output 1: master enable. Low resets the master to its CS-buffer state.
- `spi_cpol` output 1: latched CPOL to master.
- `spi_cpha` output 1: latched CPHA to master.
- `spi_w_r_mode` output 2: latched mode to master.
- `spi_wr_width` output 6: latched write width to master.
- `spi_rd_width` output 6: latched read width to master.
- `spi_wr_data` output 32: latched write word to master.
- `spi_done` input 1: one-cycle pulse from master when CS returns high.
- `spi_rd_data` input 32: master read word, valid with `spi_done`.

## Operation
States and transitions:
- **IDLE:** if any `req` bit is set, select the first requester at or after `rr_ptr`, cyclically.
  - Check the selected descriptor; the unused width is ignored per mode.
  - Illegal if: mode 11, any used width 0 or >32, or write-then-read with `wr_width+rd_width` > 63 (7-bit sum).
  - Illegal → pulse `err[i]`, advance `rr_ptr` to i+1, stay in IDLE.
  - Legal → latch all fields into the `spi_*` outputs, set `gnt[i]`, go to LOAD.
- **LOAD:** one cycle with `spi_en` = 0 and config stable, so master SCK sits at the new CPOL. Then go to RUN.
- **RUN:** `spi_en` = 1; the timeout counter increments each cycle.
  - On `spi_done`: capture `spi_rd_data` into `rd_data`, pulse `ack[i]`, go to GAP.
  - When the counter reaches `timeout_cycles-1` without `spi_done`: pulse `err[i]`, go to GAP. `rd_data` is unchanged.
- **GAP:** `spi_en` = 0 and `gnt` = 0 for `gap_cycles` cycles. Then advance `rr_ptr` to i+1 and return to IDLE.

Behaviour rules:
- Descriptor fields are sampled only in IDLE. Changes during LOAD, RUN or GAP have no effect.
- Dropping `req[i]` mid-transfer does not abort. `ack` or `err` is still issued.
- `spi_done` outside RUN is ignored.
- `spi_done` coinciding with the timeout terminal cycle counts as success: `ack`, no `err`.
- Requester priority is fair: no requester waits more than `req_num-1` grants.

## Timing
- **Reset values:**
  - `gnt`, `ack`, `err`, `spi_en` = 0; `rd_data` = 0.
  - `spi_cpol` = 0, `spi_cpha` = 0, `spi_w_r_mode` = 01, widths = 0, `spi_wr_data` = 0.
  - `rr_ptr` = 0, state IDLE.
- **Reset mid-operation:** all of the above apply asynchronously. `spi_en` falls immediately, and no `ack`/`err` is issued for the interrupted transfer.
- **Start latency:** `req` sampled at edge t gives `gnt` and latched config at t+1, and `spi_en` high at t+2.
- **Reject latency:** `err` is high in the cycle after the sampling edge.
- **Completion latency:** `spi_done` at edge d gives `ack`/`rd_data` at d+1 and `spi_en` low at d+1.
- **Back-to-back grant:** earliest next `gnt` at d+1+`gap_cycles`+1.
- **Timeout:** `err` asserts `timeout_cycles` cycles after `spi_en` rose.

## Structure
- Shared package `spi_pkg`:
  - mode encodings (`MODE_RD`, `MODE_WR`, `MODE_WR_RD`);
  - `SPI_MAX_WIDTH` = 32;
  - the 2-bit state encoding (IDLE, LOAD, RUN, GAP).
- Sub-module `spi_rr_picker`: combinational round-robin one-hot select from `req` and `rr_ptr`, with an index output.
- The arbiter top holds the FSM, descriptor registers, timeout counter and gap counter.

## Test plan
- **Single request:** `req[1]` with mode 01, `wr_width` 8, data 0xA5000000, CPOL 1, CPHA 0 → `gnt` = 0010. `spi_cpol` is 1 during LOAD, `spi_en` rises 2 cycles after `req`, and the model's `spi_done` yields an `ack[1]` pulse.
- **Contention:** all 4 `req` high continuously → grant order 0,1,2,3,0. GAP is exactly 2 cycles of `spi_en` low between grants.
- **Reject:** `req[2]` with mode 11, or mode 10 with `rd_width` 0 → `err[2]` 1 cycle later, no `gnt`, `spi_en` stays 0. The next request goes to 3 then 0.
- **Timeout:** with `timeout_cycles` = 16 and no `spi_done` → `err` asserts 16 cycles after `spi_en` rose, `spi_en` low, `rd_data` unchanged.
- **Read data:** mode 10, widths 8+24, model returns 0x00123456 → `rd_data` = 0x00123456 with `ack`. Also `spi_done` on the timeout terminal cycle → `ack` only.
- **Reset mid-RUN:** `rst_n` low during RUN → `spi_en`/`gnt` drop immediately. After release, the FSM is in IDLE and `rr_ptr` = 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI arbiter: transfer-mode
//               encodings, maximum shift width, FSM state encoding and the
//               descriptor legality check used when a requester is selected.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic [1:0] MODE_RD    = 2'b00;
    localparam logic [1:0] MODE_WR    = 2'b01;
    localparam logic [1:0] MODE_WR_RD = 2'b10;

    localparam int SPI_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // A width that the selected mode does not use is ignored. For
    // write-then-read the combined frame must fit in 63 bits, so 32+32 is
    // rejected even though each half is individually legal.
    function automatic logic desc_legal(input logic [1:0] mode,
                                        input logic [5:0] wr_w,
                                        input logic [5:0] rd_w);
        logic       wr_ok;
        logic       rd_ok;
        logic [6:0] sum;
        wr_ok = (wr_w != 6'd0) && (wr_w <= 6'(SPI_MAX_WIDTH));
        rd_ok = (rd_w != 6'd0) && (rd_w <= 6'(SPI_MAX_WIDTH));
        sum   = 7'(wr_w) + 7'(rd_w);
        case (mode)
            MODE_RD:    return rd_ok;
            MODE_WR:    return wr_ok;
            MODE_WR_RD: return wr_ok && rd_ok && (sum <= 7'd63);
            default:    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_picker
// Description : Combinational round-robin selector. Picks the first set
//               request bit at or after the pointer, wrapping cyclically.
// Ports       : req_i    - request vector
//               ptr_i    - current round-robin pointer (0..REQ_NUM-1)
//               valid_o  - any request present
//               onehot_o - one-hot winner (all zero when no request)
//               idx_o    - binary index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_picker
    import spi_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int PTR_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [REQ_NUM-1:0] onehot_o,
    output logic [PTR_W-1:0]   idx_o
);

    always_comb begin
        int pos;
        pos      = 0;
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        // Scan from the farthest offset down so the nearest requester at or
        // after the pointer is the last (winning) assignment.
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= REQ_NUM) begin
                pos = pos - REQ_NUM;
            end
            if (req_i[PTR_W'(pos)]) begin
                valid_o = 1'b1;
                idx_o   = PTR_W'(pos);
            end
        end
        if (valid_o) begin
            onehot_o = REQ_NUM'(1) << idx_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Round-robin scheduler sharing one SPI master between
//               REQ_NUM requesters. Latches the winner's descriptor, drives
//               the master's configuration and enable, returns read data with
//               an acknowledge, rejects malformed descriptors and aborts hung
//               transfers with a watchdog.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_*_i               - per-requester request + descriptor
//               gnt_o / ack_o / err_o - per-requester grant, done, error
//               rd_data_o             - last successfully read word
//               spi_*_o               - latched configuration + enable
//               spi_done_i            - master completion pulse
//               spi_rd_data_i         - master read word (valid with done)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int REQ_NUM        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQ_NUM-1:0]    req_i,
    input  logic [2*REQ_NUM-1:0]  req_w_r_mode_i,
    input  logic [6*REQ_NUM-1:0]  req_wr_width_i,
    input  logic [6*REQ_NUM-1:0]  req_rd_width_i,
    input  logic [32*REQ_NUM-1:0] req_wr_data_i,
    input  logic [REQ_NUM-1:0]    req_cpol_i,
    input  logic [REQ_NUM-1:0]    req_cpha_i,
    output logic [REQ_NUM-1:0]    gnt_o,
    output logic [REQ_NUM-1:0]    ack_o,
    output logic [REQ_NUM-1:0]    err_o,
    output logic [31:0]           rd_data_o,
    output logic                  spi_en_o,
    output logic                  spi_cpol_o,
    output logic                  spi_cpha_o,
    output logic [1:0]            spi_w_r_mode_o,
    output logic [5:0]            spi_wr_width_o,
    output logic [5:0]            spi_rd_width_o,
    output logic [31:0]           spi_wr_data_o,
    input  logic                  spi_done_i,
    input  logic [31:0]           spi_rd_data_i
);

    localparam int c_PTR_W = $clog2(REQ_NUM);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    // ------------------------------------------------------------------
    // Descriptor unpacking into per-requester arrays
    // ------------------------------------------------------------------
    logic [1:0]  w_mode_arr [REQ_NUM];
    logic [5:0]  w_wrw_arr  [REQ_NUM];
    logic [5:0]  w_rdw_arr  [REQ_NUM];
    logic [31:0] w_wrd_arr  [REQ_NUM];

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
        assign w_mode_arr[g] = req_w_r_mode_i[2*g +: 2];
        assign w_wrw_arr[g]  = req_wr_width_i[6*g +: 6];
        assign w_rdw_arr[g]  = req_rd_width_i[6*g +: 6];
        assign w_wrd_arr[g]  = req_wr_data_i[32*g +: 32];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [c_PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [c_PTR_W-1:0]   sel_q,     sel_d;
    logic [REQ_NUM-1:0]   gnt_q,     gnt_d;
    logic [REQ_NUM-1:0]   ack_q,     ack_d;
    logic [REQ_NUM-1:0]   err_q,     err_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 en_q,      en_d;
    logic                 cpol_q,    cpol_d;
    logic                 cpha_q,    cpha_d;
    logic [1:0]           mode_q,    mode_d;
    logic [5:0]           wrw_q,     wrw_d;
    logic [5:0]           rdw_q,     rdw_d;
    logic [31:0]          wrd_q,     wrd_d;
    logic [c_TMO_W-1:0]   tmo_q,     tmo_d;
    logic [c_GAP_W-1:0]   gap_q,     gap_d;

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic               w_pick_valid;
    logic [REQ_NUM-1:0] w_pick_onehot;
    logic [c_PTR_W-1:0] w_pick_idx;
    logic               w_pick_legal;

    spi_rr_picker #(
        .REQ_NUM (REQ_NUM),
        .PTR_W   (c_PTR_W)
    ) u_picker (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (w_pick_valid),
        .onehot_o (w_pick_onehot),
        .idx_o    (w_pick_idx)
    );

    assign w_pick_legal = desc_legal(w_mode_arr[w_pick_idx],
                                     w_wrw_arr[w_pick_idx],
                                     w_rdw_arr[w_pick_idx]);

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] idx);
        if (idx == c_PTR_W'(REQ_NUM - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        err_d     = '0;
        rd_data_d = rd_data_q;
        en_d      = en_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        mode_d    = mode_q;
        wrw_d     = wrw_q;
        rdw_d     = rdw_q;
        wrd_d     = wrd_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    if (w_pick_legal) begin
                        cpol_d  = req_cpol_i[w_pick_idx];
                        cpha_d  = req_cpha_i[w_pick_idx];
                        mode_d  = w_mode_arr[w_pick_idx];
                        wrw_d   = w_wrw_arr[w_pick_idx];
                        rdw_d   = w_rdw_arr[w_pick_idx];
                        wrd_d   = w_wrd_arr[w_pick_idx];
                        gnt_d   = w_pick_onehot;
                        sel_d   = w_pick_idx;
                        state_d = ST_LOAD;
                    end else begin
                        // Rejected without touching the bus; the pointer
                        // still moves on so a bad requester cannot starve
                        // the others.
                        err_d    = w_pick_onehot;
                        rr_ptr_d = next_ptr(w_pick_idx);
                    end
                end
            end

            ST_LOAD: begin
                // Config has been stable with the master held in reset for
                // this cycle, so SCK already idles at the new CPOL.
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // Completion wins over the watchdog on the terminal cycle.
                if (spi_done_i) begin
                    rd_data_d = spi_rd_data_i;
                    ack_d     = gnt_q;
                    gnt_d     = '0;
                    en_d      = 1'b0;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else if (tmo_q == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == c_GAP_W'(GAP_CYCLES - 1)) begin
                    rr_ptr_d = next_ptr(sel_q);
                    state_d  = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            en_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            mode_q    <= MODE_WR;
            wrw_q     <= '0;
            rdw_q     <= '0;
            wrd_q     <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            en_q      <= en_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            mode_q    <= mode_d;
            wrw_q     <= wrw_d;
            rdw_q     <= rdw_d;
            wrd_q     <= wrd_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign ack_o          = ack_q;
    assign err_o          = err_q;
    assign rd_data_o      = rd_data_q;
    assign spi_en_o       = en_q;
    assign spi_cpol_o     = cpol_q;
    assign spi_cpha_o     = cpha_q;
    assign spi_w_r_mode_o = mode_q;
    assign spi_wr_width_o = wrw_q;
    assign spi_rd_width_o = rdw_q;
    assign spi_wr_data_o  = wrd_q;

endmodule
`default_nettype wire
